// File: rtl/mux_arb_pkg.sv
// Shared defaults, index type and pointer-increment helper for the
// round-robin mux arbiter.
package mux_arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 8;
  localparam int IDX_W_DEF = $clog2(N_REQ_DEF);

  typedef logic [IDX_W_DEF-1:0] idx_t;

  // Requester counts are powers of two, so wrap is a mask with N-1.
  function automatic logic [7:0] next_idx(input logic [7:0] idx,
                                          input logic [7:0] mask);
    return (idx + 8'd1) & mask;
  endfunction
endpackage

// File: rtl/mux_tree_sel.sv
// N-to-1 data selector built as log2(N) levels of 2:1 muxes; level l is
// steered by select bit l-1.
module mux_tree_sel #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [$clog2(N)-1:0] i_sel,
  input  logic [N*W-1:0]       i_data,
  output logic [W-1:0]         o_data
);
  localparam int SEL_W = $clog2(N);

  for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
    logic [W-1:0] node [N>>l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_i
        assign node[i] = i_data[i*W +: W];
      end
    end else begin : g_mux
      for (genvar k = 0; k < (N>>l); k++) begin : g_k
        assign node[k] = i_sel[l-1] ? g_lvl[l-1].node[2*k+1] : g_lvl[l-1].node[2*k];
      end
    end
  end

  assign o_data = g_lvl[SEL_W].node[0];
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output channel
// among N_REQ requesters; the data path runs through a 2:1 mux tree.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(N_REQ)-1:0] out_src,
  input  logic                     out_ready
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W-1:0] w_winner;
  logic [N_REQ-1:0] w_rot;
  logic             w_any;
  logic             w_can_load;
  logic             w_accept;
  logic [W-1:0]     w_sel_data;

  assign w_start = IDX_W'(next_idx(8'(r_last), 8'(N_REQ - 1)));

  // Rotate so bit 0 is the highest-priority requester this cycle.
  always_comb begin
    logic [IDX_W-1:0] k;
    w_rot = '0;
    k     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      k        = w_start + IDX_W'(j);
      w_rot[j] = req_valid[k];
    end
  end

  always_comb begin
    w_any = |w_rot;
    w_off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = IDX_W'(j);
    end
  end

  assign w_winner   = w_start + w_off;
  assign w_can_load = !out_valid || out_ready;
  assign w_accept   = w_any && w_can_load;
  assign req_ready  = w_accept ? (N_REQ'(1) << w_winner) : '0;

  mux_tree_sel #(.N(N_REQ), .W(W)) u_sel (
    .i_sel  (w_winner),
    .i_data (req_data),
    .o_data (w_sel_data)
  );

  // Output register and priority pointer; the pointer moves only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      r_last    <= IDX_W'(N_REQ - 1);
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_data  <= w_sel_data;
      out_src   <= w_winner;
      r_last    <= w_winner;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mux_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state of the output channel and last-granted index.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_last;

  function automatic int m_winner();
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (m_last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    int w;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= 0;
      m_last  <= N - 1;
    end else begin
      w = m_winner();
      if (w >= 0 && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_data  <= req_data[w*W +: W];
        m_src   <= w;
        m_last  <= w;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int w;
    logic [N-1:0] er;
    if (!rst) begin
      w  = m_winner();
      er = (w >= 0 && (!m_valid || out_ready)) ? (N'(1) << w) : '0;
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_out_data",  32'(out_data),  32'(m_data));
      check("cyc_out_src",   32'(out_src),   32'(m_src));
      check("cyc_req_ready", 32'(req_ready), 32'(er));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sp [4];
    sp = '{3, 1, 3, 1};
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_src",   32'(out_src),   32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("idle_req_ready", 32'(req_ready), 32'd0);
      check("idle_out_valid", 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'hA0 + 8'(i);
    req_valid = 4'hF;
    #1;
    check("cont_first_ready", 32'(req_ready), 32'h1);
    for (int c = 0; c < 8; c++) begin
      step();
      check("cont_valid", 32'(out_valid), 32'd1);
      check("cont_src",   32'(out_src),   32'(c % 4));
      check("cont_data",  32'(out_data),  32'(8'hA0 + 8'(c % 4)));
    end

    step();
    check("bp_pre_src0", 32'(out_src), 32'd0);
    step();
    check("bp_hold_src", 32'(out_src), 32'd1);
    out_ready = 1'b0;
    #1;
    check("bp_ready_zero", 32'(req_ready), 32'd0);
    repeat (3) begin
      step();
      check("bp_hold_src",   32'(out_src),   32'd1);
      check("bp_hold_data",  32'(out_data),  32'hA1);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_ready_zero", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(req_ready), 32'h4);
    step();
    check("bp_resume_src",  32'(out_src),  32'd2);
    check("bp_resume_data", 32'(out_data), 32'hA2);

    req_valid = 4'b1010;
    #1;
    check("sparse_first_ready", 32'(req_ready), 32'h8);
    for (int c = 0; c < 4; c++) begin
      step();
      check("sparse_src", 32'(out_src), 32'(sp[c]));
      check("sparse_no_0_2", 32'(req_ready & 4'b0101), 32'd0);
    end

    req_valid = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      step();
      check("single_src",   32'(out_src),   32'd2);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_ready", 32'(req_ready), 32'h4);
    end

    req_valid = 4'b0001;
    step();
    check("wd_setup_src", 32'(out_src), 32'd0);
    out_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    check("wd_stall_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = 4'b1000;
    out_ready = 1'b1;
    #1;
    check("wd_ready", 32'(req_ready), 32'h8);
    step();
    check("wd_src",  32'(out_src),  32'd3);
    check("wd_data", 32'(out_data), 32'hA3);

    req_valid = '0;
    step();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_req_ready", 32'(req_ready), 32'd0);

    req_valid = 4'hF;
    step();
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    check("post_rst_src",  32'(out_src),  32'd0);
    check("post_rst_data", 32'(out_data), 32'hA0);

    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one registered output channel among N_REQ valid/ready requesters. It is the scheduler in front of a 2:1-mux-tree data selector: it decides each cycle which requester drives the shared channel, steers the select lines, and holds the result stable until the consumer accepts it. It sits between multiple producer blocks and a single downstream consumer in the combinational-logic exercise datapath.

## Interface
- N_REQ, default 4: number of requesters, a power of two in the range 2–8.
- W, default 8: data width in bits.
- clk  input  1: clock; all state updates on the rising edge.
- rst  input  1: asynchronous, active-high reset.
- req_valid  input  N_REQ: requester i has data.
- req_data  input  N_REQ*W: requester i's data in bits [i*W +: W].
- req_ready  output  N_REQ: one-hot or zero; requester i is accepted this cycle.
- out_valid  output  1: output register holds data.
- out_data  output  W: registered selected data.
- out_src  output  $clog2(N_REQ): index of the requester that supplied out_data.
- out_ready  input  1: consumer accepts the output this cycle.

## Operation
- A transfer on any interface occurs when valid && ready are both high in the same cycle.
- can_load = !out_valid || out_ready.
- Grant search:
  - Start at (last + 1) mod N_REQ and wrap around.
  - The first i with req_valid[i] is the winner.
  - The search uses only req_valid and last; it never uses out_ready.
- req_ready[winner] = can_load. Every other req_ready bit is 0. If no requester is valid, req_ready is all zero.
- On an accept at the clock edge:
  - out_data ← winner's data.
  - out_src ← winner.
  - out_valid ← 1.
  - last ← winner.
- If out_valid && out_ready and there is no accept, out_valid ← 0.
- If out_valid && !out_ready:
  - out_data and out_src hold.
  - req_ready is all zero.
  - last holds.
- `last` changes only on an accept, so a stalled consumer never skips a requester.
- A requester may drop req_valid without a handshake. The next search then ignores it.
- With a single active requester, it is granted every cycle.
- With all requesters continuously valid and out_ready high, the grant order is 0, 1, 2, …, N_REQ−1, 0, …

## Timing
- Reset values:
  - out_valid = 0.
  - out_data = 0.
  - out_src = 0.
  - last = N_REQ−1, so requester 0 has first priority.
- req_ready is combinational from req_valid, last, out_valid and out_ready. There is no combinational path from req_data.
- Latency is 1 cycle: data accepted at edge k appears on out_data after edge k.
- Throughput is one transfer per cycle when out_ready is held high, with no bubble on simultaneous drain and load.
- An asynchronous rst asserted mid-transfer clears out_valid immediately. Any in-flight item is dropped. After deassertion, the grant search restarts from requester 0.
- Deassert rst synchronously to clk. The first accept can occur on the first edge after deassertion.

## Structure
- Package mux_arb_pkg holds:
  - N_REQ_DEF and W_DEF.
  - The idx_t typedef, logic [$clog2(N_REQ)-1:0].
  - The function next_idx(idx), which increments with wrap.
- Sub-module mux_tree_sel:
  - Parameterised N/W selector built from log2(N) levels of the 2:1 mux.
  - Inputs are the select index and the flat data; the output is the W-bit data.
  - The arbiter instantiates it for the data path.
- The arbiter top contains:
  - The round-robin search, as a rotate → priority-encode → un-rotate.
  - The output register.
  - The last pointer.

## Test plan
- Reset and idle: assert rst mid-simulation while out_valid = 1 → out_valid = 0 and out_data = 0 immediately. Idle with all req_valid low → req_ready = 0 and out_valid stays 0.
- Full contention: N_REQ = 4, all valid, data 8'hA0 + i, out_ready = 1 for 8 cycles → out_src sequence 0, 1, 2, 3, 0, 1, 2, 3 and out_data A0, A1, A2, A3, … with out_valid high every cycle after the first.
- Backpressure: out_ready = 0 for 3 cycles while holding src 1, data A1 → out_data stays A1, req_ready = 0. When out_ready rises, the next grant is requester 2, not 3.
- Sparse requests: only requesters 1 and 3 are valid → grants alternate 1, 3, 1, 3; requesters 0 and 2 never see req_ready.
- Single requester: only requester 2 is valid, out_ready = 1 → accepted every cycle with continuous out_valid and no bubbles.
- Withdrawal: requester 1 drops valid in the cycle it would be next (last = 0, requesters 1 and 3 valid, requester 1 withdraws) → grant goes to 3, and req_ready[1] is never asserted.
